// File: rtl/tft_video_timing_if.sv
// Upstream pixel stream between the line FIFO and the TFT timing generator.
//   iPixel      : RGB444 pixel {R[11:8],G[7:4],B[3:0]} offered by the FIFO
//   iPixelValid : FIFO has a pixel on iPixel
//   oPixelReady : timing generator takes the pixel this cycle (with iPixelValid)
// master = FIFO side, slave = timing generator side.
interface tft_video_timing_if;
  logic [11:0] iPixel;
  logic        iPixelValid;
  logic        oPixelReady;

  modport master (output iPixel, output iPixelValid, input oPixelReady);
  modport slave  (input iPixel, input iPixelValid, output oPixelReady);
endinterface

// File: rtl/tft_video_timing.sv
// TFT raster timing generator with RGB444 pixel pull from the upstream FIFO.
// Counts hcnt/vcnt over the full raster (active, front porch, sync, back
// porch), pulls one pixel per active clock and drives registered pixel, data
// enable, Hsync, Vsync, position, frame-start and underflow outputs, all one
// clock behind the counter state.
// Ports:
//   iPixelClk      pixel clock
//   iSysRst        asynchronous active-low reset
//   iEnable        run timing (low = idle, counters held at 0)
//   up             pixel stream from the line FIFO (slave side)
//   iUnderflowClr  clears the sticky underflow flag
//   iPatternSel    colour-bar select (only with TFT_TIMING_TEST_PATTERN_EN)
//   oPixel, oVde, oHsync, oVsync, oHpos, oVpos, oFrameStart, oUnderflow
// Optional macro: TFT_TIMING_TEST_PATTERN_EN adds the 8-bar test pattern.
module tft_video_timing #(
  parameter int          H_DISPLAY       = 480,
  parameter int          H_FRONT         = 2,
  parameter int          H_PULSE         = 41,
  parameter int          H_BACK          = 2,
  parameter int          V_DISPLAY       = 272,
  parameter int          V_FRONT         = 2,
  parameter int          V_PULSE         = 10,
  parameter int          V_BACK          = 2,
  parameter int          CNT_W           = 10,
  parameter logic        SYNC_POL        = 1'b0,
  parameter logic [11:0] UNDERFLOW_COLOR = 12'h000
) (
  input  logic             iPixelClk,
  input  logic             iSysRst,
  input  logic             iEnable,
  tft_video_timing_if.slave up,
  input  logic             iUnderflowClr,
  input  logic             iPatternSel,
  output logic [11:0]      oPixel,
  output logic             oVde,
  output logic             oHsync,
  output logic             oVsync,
  output logic [CNT_W-1:0] oHpos,
  output logic [CNT_W-1:0] oVpos,
  output logic             oFrameStart,
  output logic             oUnderflow
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_PULSE + V_BACK;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_PULSE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_PULSE);

`ifdef TFT_TIMING_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_DISPLAY / 8);

  // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 12'hFFF;
      3'd1:    bar_color = 12'hFF0;
      3'd2:    bar_color = 12'h0FF;
      3'd3:    bar_color = 12'h0F0;
      3'd4:    bar_color = 12'hF0F;
      3'd5:    bar_color = 12'hF00;
      3'd6:    bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction
`endif

  logic             run_r;
  logic [CNT_W-1:0] hcnt_r;
  logic [CNT_W-1:0] vcnt_r;
  logic             active_s;
  logic             pattern_s;
  logic [11:0]      bar_s;
  logic [11:0]      pixel_next_s;
  logic             underflow_set_s;
  logic             hsync_on_s;
  logic             vsync_on_s;

  // Raster decode, FIFO handshake and next-pixel selection from registered state.
  always_comb begin
    active_s   = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
    hsync_on_s = (hcnt_r >= HS_START) && (hcnt_r < HS_END);
    vsync_on_s = (vcnt_r >= VS_START) && (vcnt_r < VS_END);
`ifdef TFT_TIMING_TEST_PATTERN_EN
    pattern_s = iPatternSel;
    bar_s     = bar_color(3'(hcnt_r / BAR_W));
`else
    // Port kept for pin compatibility; it has no effect in this build.
    pattern_s = iPatternSel & 1'b0;
    bar_s     = 12'h000;
`endif
    // Pattern mode leaves the FIFO untouched and never reports underflow.
    up.oPixelReady  = run_r && active_s && !pattern_s;
    underflow_set_s = run_r && active_s && !pattern_s && !up.iPixelValid;
    pixel_next_s    = 12'h000;
    if (run_r && active_s) begin
      if (pattern_s) begin
        pixel_next_s = bar_s;
      end else if (up.iPixelValid) begin
        pixel_next_s = up.iPixel;
      end else begin
        pixel_next_s = UNDERFLOW_COLOR;
      end
    end else begin
      pixel_next_s = 12'h000;
    end
  end

  // Run flag and raster counters; counters sit at (0,0) whenever not running.
  always_ff @(posedge iPixelClk or negedge iSysRst) begin
    if (!iSysRst) begin
      run_r  <= 1'b0;
      hcnt_r <= '0;
      vcnt_r <= '0;
    end else begin
      run_r <= iEnable;
      if (!run_r) begin
        hcnt_r <= '0;
        vcnt_r <= '0;
      end else if (hcnt_r == H_LAST) begin
        hcnt_r <= '0;
        vcnt_r <= (vcnt_r == V_LAST) ? '0 : vcnt_r + CNT_ONE;
      end else begin
        hcnt_r <= hcnt_r + CNT_ONE;
      end
    end
  end

  // Registered outputs, one clock behind the counter state; idle values when not running.
  always_ff @(posedge iPixelClk or negedge iSysRst) begin
    if (!iSysRst) begin
      oPixel      <= 12'h000;
      oVde        <= 1'b0;
      oHsync      <= ~SYNC_POL;
      oVsync      <= ~SYNC_POL;
      oHpos       <= '0;
      oVpos       <= '0;
      oFrameStart <= 1'b0;
      oUnderflow  <= 1'b0;
    end else if (!run_r) begin
      oPixel      <= 12'h000;
      oVde        <= 1'b0;
      oHsync      <= ~SYNC_POL;
      oVsync      <= ~SYNC_POL;
      oHpos       <= '0;
      oVpos       <= '0;
      oFrameStart <= 1'b0;
      oUnderflow  <= 1'b0;
    end else begin
      oPixel      <= pixel_next_s;
      oVde        <= active_s;
      oHsync      <= hsync_on_s ? SYNC_POL : ~SYNC_POL;
      oVsync      <= vsync_on_s ? SYNC_POL : ~SYNC_POL;
      oHpos       <= hcnt_r;
      oVpos       <= vcnt_r;
      oFrameStart <= (hcnt_r == '0) && (vcnt_r == '0);
      // A new miss beats a simultaneous clear so no event is lost.
      oUnderflow  <= underflow_set_s ? 1'b1 : (iUnderflowClr ? 1'b0 : oUnderflow);
    end
  end

endmodule

// File: tb/tb_tft_video_timing.sv
// Directed bench for tft_video_timing on a reduced raster:
//   H: 16 active, 2 front, 4 sync, 2 back -> 24 clocks/line, Hsync at 18..21
//   V:  6 active, 1 front, 2 sync, 1 back -> 10 lines/frame, Vsync lines 7..8
//   240 clocks per frame, active-low syncs, underflow colour 12'hA5A.
module tb_tft_video_timing;
  localparam int HT = 24;
  localparam int VT = 10;
  localparam logic [11:0] UF_COL = 12'hA5A;
  localparam logic [37:0] IDLE = {12'h000, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic        psel;
  logic [11:0] o_pixel;
  logic        o_vde;
  logic        o_hs;
  logic        o_vs;
  logic [9:0]  o_hpos;
  logic [9:0]  o_vpos;
  logic        o_fs;
  logic        o_uf;

  int checks;
  int errors;
  int cur_h;
  int cur_v;

  tft_video_timing_if up_if ();

  tft_video_timing #(
    .H_DISPLAY(16), .H_FRONT(2), .H_PULSE(4), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_PULSE(2), .V_BACK(1),
    .CNT_W(10), .SYNC_POL(1'b0), .UNDERFLOW_COLOR(UF_COL)
  ) dut (
    .iPixelClk(clk), .iSysRst(rst_n), .iEnable(en), .up(up_if),
    .iUnderflowClr(clr), .iPatternSel(psel),
    .oPixel(o_pixel), .oVde(o_vde), .oHsync(o_hs), .oVsync(o_vs),
    .oHpos(o_hpos), .oVpos(o_vpos), .oFrameStart(o_fs), .oUnderflow(o_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pix_of(input int h, input int v);
    return 12'h800 | 12'(v * 32 + h);
  endfunction

  function automatic logic [37:0] snap();
    return {o_pixel, o_vde, o_hs, o_vs, o_hpos, o_vpos, o_fs, o_uf, up_if.oPixelReady};
  endfunction

  // Drive the inputs for counter state (cur_h,cur_v), sample ready, advance one clock.
  task automatic step(input logic valid, output logic rdy);
    up_if.iPixelValid = valid;
    up_if.iPixel      = pix_of(cur_h, cur_v);
    #1;
    rdy = up_if.oPixelReady;
    @(negedge clk);
    cur_h = cur_h + 1;
    if (cur_h == HT) begin
      cur_h = 0;
      cur_v = (cur_v + 1) % VT;
    end
  endtask

  task automatic test_reset();
    logic [37:0] s;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; psel = 1'b0;
    up_if.iPixelValid = 1'b1; up_if.iPixel = 12'hFFF;
    repeat (3) @(negedge clk);
    s = snap();
    checks++;
    if (s !== IDLE) begin
      errors++; $display("FAIL reset_state got %h want %h", s, IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_vde !== 1'b0 || up_if.oPixelReady !== 1'b1) begin
      errors++; $display("FAIL first_edge vde=%b rdy=%b want vde=0 rdy=1", o_vde, up_if.oPixelReady);
    end
    cur_h = 0; cur_v = 0;
  endtask

  task automatic test_frame();
    int vde_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
    int bad_rdy = 0, bad_vde = 0, bad_hs = 0, bad_vs = 0, bad_pos = 0, bad_pix = 0, bad_fs = 0;
    logic first_vde = 1'b0;
    logic rdy, act;
    int h, v;
`ifndef TFT_TIMING_TEST_PATTERN_EN
    psel = 1'b1;
`endif
    for (int t = 0; t < HT * VT; t++) begin
      h = cur_h; v = cur_v;
      act = (h < 16) && (v < 6);
      step(1'b1, rdy);
      if (t == 0) first_vde = o_vde;
      if (rdy !== act) bad_rdy++;
      if (o_vde === 1'b1) vde_cnt++;
      if (o_hs === 1'b0) hs_cnt++;
      if (o_vs === 1'b0) vs_cnt++;
      if (o_fs === 1'b1) begin
        fs_cnt++;
        if (h != 0 || v != 0) bad_fs++;
      end
      if (o_vde !== act) bad_vde++;
      if (o_hs !== !((h >= 18) && (h < 22))) bad_hs++;
      if (o_vs !== !((v >= 7) && (v < 9))) bad_vs++;
      if (o_hpos !== 10'(h) || o_vpos !== 10'(v)) bad_pos++;
      if (o_pixel !== (act ? pix_of(h, v) : 12'h000)) bad_pix++;
    end
    psel = 1'b0;
    checks++; if (first_vde !== 1'b1) begin errors++; $display("FAIL vde_latency got %b want 1", first_vde); end
    checks++; if (vde_cnt !== 96) begin errors++; $display("FAIL vde_count got %0d want 96", vde_cnt); end
    checks++; if (hs_cnt !== 40) begin errors++; $display("FAIL hsync_count got %0d want 40", hs_cnt); end
    checks++; if (vs_cnt !== 48) begin errors++; $display("FAIL vsync_count got %0d want 48", vs_cnt); end
    checks++; if (fs_cnt !== 1 || bad_fs !== 0) begin errors++; $display("FAIL frame_start got %0d (%0d misplaced) want 1", fs_cnt, bad_fs); end
    checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL ready_region got %0d bad want 0", bad_rdy); end
    checks++; if (bad_vde !== 0) begin errors++; $display("FAIL vde_region got %0d bad want 0", bad_vde); end
    checks++; if (bad_hs !== 0 || bad_vs !== 0) begin errors++; $display("FAIL sync_place got hs %0d vs %0d bad want 0", bad_hs, bad_vs); end
    checks++; if (bad_pos !== 0) begin errors++; $display("FAIL position got %0d bad want 0", bad_pos); end
    checks++; if (bad_pix !== 0) begin errors++; $display("FAIL pixel_data got %0d bad want 0", bad_pix); end
    checks++; if (o_uf !== 1'b0) begin errors++; $display("FAIL no_underflow got %b want 0", o_uf); end
  endtask

  task automatic test_underflow();
    int bad_pix = 0, bad_uf = 0;
    logic fs0 = 1'b0;
    logic rdy, act, valid, uf_exp;
    int h, v;
    for (int t = 0; t < HT * VT; t++) begin
      h = cur_h; v = cur_v;
      act = (h < 16) && (v < 6);
      valid = !((v == 2) && (h == 5 || h == 6 || h == 16 || h == 17)) && !((v == 6) && (h == 3));
      step(valid, rdy);
      if (t == 0) fs0 = o_fs;
      uf_exp = (v > 2) || ((v == 2) && (h >= 5));
      if (o_uf !== uf_exp) bad_uf++;
      if (o_pixel !== (act ? (valid ? pix_of(h, v) : UF_COL) : 12'h000)) bad_pix++;
    end
    checks++; if (fs0 !== 1'b1) begin errors++; $display("FAIL frame_wrap got fs=%b want 1", fs0); end
    checks++; if (bad_uf !== 0) begin errors++; $display("FAIL underflow_sticky got %0d bad want 0", bad_uf); end
    checks++; if (bad_pix !== 0) begin errors++; $display("FAIL underflow_pixel got %0d bad want 0", bad_pix); end
  endtask

  task automatic test_underflow_clear();
    logic rdy;
    clr = 1'b1; step(1'b1, rdy);
    checks++; if (o_uf !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", o_uf); end
    clr = 1'b1; step(1'b0, rdy);
    checks++; if (o_uf !== 1'b1 || o_pixel !== UF_COL) begin errors++; $display("FAIL uf_set_wins got uf=%b pix=%h want 1 %h", o_uf, o_pixel, UF_COL); end
    clr = 1'b0; step(1'b1, rdy);
    checks++; if (o_uf !== 1'b1) begin errors++; $display("FAIL uf_hold got %b want 1", o_uf); end
    clr = 1'b1; step(1'b1, rdy);
    clr = 1'b0; step(1'b0, rdy);
    checks++; if (o_uf !== 1'b1) begin errors++; $display("FAIL uf_reset got %b want 1", o_uf); end
  endtask

  task automatic test_enable_drop();
    logic rdy;
    logic [37:0] s;
    int bad_idle = 0;
    for (int i = 0; i < HT * VT && !(cur_h == 8 && cur_v == 3); i++) step(1'b1, rdy);
    en = 1'b0;
    step(1'b1, rdy);
    checks++;
    if (o_vde !== 1'b1 || o_hpos !== 10'd8 || o_vpos !== 10'd3 || up_if.oPixelReady !== 1'b0) begin
      errors++; $display("FAIL drop_edge got vde=%b pos=%0d,%0d rdy=%b want 1 8,3 0", o_vde, o_hpos, o_vpos, up_if.oPixelReady);
    end
    step(1'b1, rdy);
    s = snap();
    checks++; if (s !== IDLE) begin errors++; $display("FAIL drop_idle got %h want %h", s, IDLE); end
    repeat (3) begin
      step(1'b1, rdy);
      if (snap() !== IDLE) bad_idle++;
    end
    checks++; if (bad_idle !== 0) begin errors++; $display("FAIL idle_hold got %0d bad want 0", bad_idle); end
    en = 1'b1;
    step(1'b1, rdy);
    checks++;
    if (o_fs !== 1'b0 || o_vde !== 1'b0 || up_if.oPixelReady !== 1'b1) begin
      errors++; $display("FAIL reenable_edge got fs=%b vde=%b rdy=%b want 0 0 1", o_fs, o_vde, up_if.oPixelReady);
    end
    cur_h = 0; cur_v = 0;
    step(1'b1, rdy);
    checks++;
    if (o_fs !== 1'b1 || o_vde !== 1'b1 || o_hpos !== 10'd0 || o_vpos !== 10'd0) begin
      errors++; $display("FAIL restart got fs=%b vde=%b pos=%0d,%0d want 1 1 0,0", o_fs, o_vde, o_hpos, o_vpos);
    end
  endtask

`ifdef TFT_TIMING_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [11:0] bars [8];
    int bad_rdy = 0, bad_pix = 0, bad_uf = 0;
    logic rdy, act;
    int h, v;
    bars[0] = 12'hFFF; bars[1] = 12'hFF0; bars[2] = 12'h0FF; bars[3] = 12'h0F0;
    bars[4] = 12'hF0F; bars[5] = 12'hF00; bars[6] = 12'h00F; bars[7] = 12'h000;
    clr = 1'b1; step(1'b1, rdy); clr = 1'b0;
    psel = 1'b1;
    for (int t = 0; t < 48; t++) begin
      h = cur_h; v = cur_v;
      act = (h < 16) && (v < 6);
      step(1'b0, rdy);
      if (rdy !== 1'b0) bad_rdy++;
      if (o_pixel !== (act ? bars[h / 2] : 12'h000)) bad_pix++;
      if (o_uf !== 1'b0) bad_uf++;
    end
    psel = 1'b0;
    checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL pattern_ready got %0d bad want 0", bad_rdy); end
    checks++; if (bad_pix !== 0) begin errors++; $display("FAIL pattern_bars got %0d bad want 0", bad_pix); end
    checks++; if (bad_uf !== 0) begin errors++; $display("FAIL pattern_uf got %0d bad want 0", bad_uf); end
  endtask
`endif

  task automatic test_async_reset();
    logic rdy;
    logic [37:0] s;
    for (int i = 0; i < HT * VT && !(cur_h == 3 && cur_v == 1); i++) step(1'b1, rdy);
    step(1'b1, rdy);
    checks++; if (o_vde !== 1'b1) begin errors++; $display("FAIL pre_reset got vde=%b want 1", o_vde); end
    #2 rst_n = 1'b0;
    #1 s = snap();
    checks++; if (s !== IDLE) begin errors++; $display("FAIL async_reset got %h want %h", s, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_frame();
    test_underflow();
    test_underflow_clear();
    test_enable_drop();
`ifdef TFT_TIMING_TEST_PATTERN_EN
    test_pattern();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
